// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial receiver and the display driver:
// register address map, frame length and receiver FSM state encoding.
package max7219_pkg;

   // Bits in one MAX7219 frame (4 ignored, 4 address, 8 data)
   localparam int unsigned FRAME_BITS = 16;

   // Register address map
   localparam logic [3:0] REG_NOOP      = 4'h0;
   localparam logic [3:0] REG_DIGIT0    = 4'h1;
   localparam logic [3:0] REG_DIGIT1    = 4'h2;
   localparam logic [3:0] REG_DIGIT2    = 4'h3;
   localparam logic [3:0] REG_DIGIT3    = 4'h4;
   localparam logic [3:0] REG_DIGIT4    = 4'h5;
   localparam logic [3:0] REG_DIGIT5    = 4'h6;
   localparam logic [3:0] REG_DIGIT6    = 4'h7;
   localparam logic [3:0] REG_DIGIT7    = 4'h8;
   localparam logic [3:0] REG_DECODE    = 4'h9;
   localparam logic [3:0] REG_INTENSITY = 4'hA;
   localparam logic [3:0] REG_SCANLIMIT = 4'hB;
   localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
   localparam logic [3:0] REG_DISPTEST  = 4'hF;

   // Receiver FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } rx_state_t;

   // Bit offset of a digit byte inside the 64-bit row vector (digit address 1..8)
   function automatic logic [5:0] digit_lsb(input logic [3:0] addr);
      return {3'(addr - REG_DIGIT0), 3'b000};
   endfunction

endpackage

// File: rtl/max7219_rx_sync.sv
// Input synchroniser for one asynchronous pin plus rise/fall edge detection
// on the synchronised level. The chain and the previous-value flop reset to 0,
// so a pin that is already low when reset releases produces no falling edge.
module max7219_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the pin through the synchroniser chain and remember the last synchronised level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219 receive-side model: oversamples DIN/SCLK/CS in the clk domain,
// shifts bits on synchronised SCLK rising edges while CS is low and latches
// the last 16 bits as a frame on the CS rising edge into the display
// register file.
// Optional build macro MAX7219_DOUT_EN adds the cascade output DOUT, which
// replays DIN delayed by 16 SCLK cycles, updated on SCLK falling edges.
module max7219_receiver
   import max7219_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DIN,
   input  logic        SCLK,
   input  logic        CS,
   output logic [63:0] rows,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        shutdown_n,
   output logic        display_test,
   output logic        frame_valid,
   output logic [3:0]  frame_addr,
   output logic [7:0]  frame_data,
   output logic        frame_error
`ifdef MAX7219_DOUT_EN
   ,
   output logic        DOUT
`endif
);

   // Synchronised pin levels and edges
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic din_lvl, din_rise, din_fall;

   // Frame assembly state
   rx_state_t                state_q, state_d;
   logic [FRAME_BITS-1:0]    shift_reg;
   logic [4:0]               bit_cnt;

   // FSM strobes into the datapath
   logic clr_frame, shift_en, latch_ok, latch_err;

   // Fields of the frame held in the shift register
   logic [3:0] rx_addr;
   logic [7:0] rx_data;

   assign rx_addr = shift_reg[11:8];
   assign rx_data = shift_reg[7:0];

   max7219_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk      (clk),
      .rst      (rst),
      .async_in (SCLK),
      .level    (sclk_lvl),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   max7219_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk      (clk),
      .rst      (rst),
      .async_in (CS),
      .level    (cs_lvl),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   max7219_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
      .clk      (clk),
      .rst      (rst),
      .async_in (DIN),
      .level    (din_lvl),
      .rise     (din_rise),
      .fall     (din_fall)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath strobes; a CS rise beats a coincident SCLK rise
   always_comb begin
      state_d   = state_q;
      clr_frame = 1'b0;
      shift_en  = 1'b0;
      latch_ok  = 1'b0;
      latch_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               clr_frame = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d = LATCH;
            end else if (sclk_rise) begin
               shift_en = 1'b1;
            end
         end
         LATCH: begin
            state_d = IDLE;
            if (bit_cnt >= 5'(FRAME_BITS)) begin
               latch_ok = 1'b1;
            end else begin
               latch_err = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shift register and saturating bit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (clr_frame) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (shift_en) begin
         shift_reg <= {shift_reg[FRAME_BITS-2:0], din_lvl};
         if (bit_cnt != 5'd31) begin
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   // Register file update and one-cycle frame status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         rows         <= '0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         shutdown_n   <= 1'b0;
         display_test <= 1'b0;
         frame_valid  <= 1'b0;
         frame_addr   <= '0;
         frame_data   <= '0;
         frame_error  <= 1'b0;
      end else begin
         frame_valid <= latch_ok;
         frame_error <= latch_err;
         if (latch_ok) begin
            frame_addr <= rx_addr;
            frame_data <= rx_data;
            case (rx_addr)
               REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
               REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
                  rows[digit_lsb(rx_addr) +: 8] <= rx_data;
               REG_DECODE:    decode_mode  <= rx_data;
               REG_INTENSITY: intensity    <= rx_data[3:0];
               REG_SCANLIMIT: scan_limit   <= rx_data[2:0];
               REG_SHUTDOWN:  shutdown_n   <= rx_data[0];
               REG_DISPTEST:  display_test <= rx_data[0];
               REG_NOOP:      ;
               default:       ;  // 0xD and 0xE accepted but hold no register
            endcase
         end
      end
   end

`ifdef MAX7219_DOUT_EN
   // Signals the receiver itself has no use for
   logic [2:0] spare_unused;
   assign spare_unused = {sclk_lvl, din_rise, din_fall};

   // Cascade output: shift out the oldest bit on SCLK falling edges while CS is low
   always_ff @(posedge clk) begin
      if (rst) begin
         DOUT <= 1'b0;
      end else if (sclk_fall && !cs_lvl) begin
         DOUT <= shift_reg[FRAME_BITS-1];
      end
   end
`else
   // Signals only consumed by the cascade output, which is not built here
   logic [5:0] spare_unused;
   assign spare_unused = {sclk_lvl, sclk_fall, din_rise, din_fall, cs_lvl,
                          shift_reg[FRAME_BITS-1]};
`endif

endmodule
